pilha_rpn_n: RTL and testbench

- Parametrised N-level RPN operand stack; successor to the fixed 2-level A/B operand stack in front of the 8-bit ALU.
- Holds up to DEPTH words of WIDTH bits and exposes the top two entries as ALU operands.
- Executes one stack command per clock: push, pop, dup, swap, reduce (ALU write-back), clear.
- Detects overflow and underflow; optional drop-oldest mode on full.

---
 rtl/pilha_rpn_n.sv | 167 ++++++++++++++++
 tb/tb_pilha_rpn_n.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pilha_rpn_n.sv
// N-level RPN operand stack feeding the ALU: the top two entries are exposed as operands A/B,
// and one stack command executes per clock, with overflow/underflow detection.
module pilha_rpn_n #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           D,
  input  logic [2:0]                 op,
  input  logic                       op_valid,
  output logic [WIDTH-1:0]           saidaA,
  output logic [WIDTH-1:0]           saidaB,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       vazia,
  output logic                       cheia,
  output logic                       erro,
  output logic                       erro_sticky
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNTW-1:0] ZERO = '0;
  localparam logic [CNTW-1:0] ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] TWO  = CNTW'(2);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_PUSH   = 3'b001,
    OP_POP    = 3'b010,
    OP_DUP    = 3'b011,
    OP_SWAP   = 3'b100,
    OP_REDUCE = 3'b101,
    OP_CLEAR  = 3'b110,
    OP_RSVD   = 3'b111
  } opT;

  logic [WIDTH-1:0] stackQ    [DEPTH];
  logic [WIDTH-1:0] stackNext [DEPTH];
  logic [CNTW-1:0]  countQ, countNext;
  logic             erroQ, erroNext;
  logic             stickyQ, stickyNext;

  opT               opCode;
  logic [IDXW-1:0]  topIdx, secIdx, freeIdx;
  logic [WIDTH-1:0] pushData;
  logic             reject;

  assign opCode  = opT'(op);
  // Indices are only used under the legality guard for their command, so truncation is harmless.
  assign topIdx  = IDXW'(countQ - ONE);
  assign secIdx  = IDXW'(countQ - TWO);
  assign freeIdx = IDXW'(countQ);

  // NOTE: combinational blocks use blocking assignments and assign every output a default
  // first, so the later branches read the updated values and no latch is ever inferred.
  always_comb begin
    stackNext  = stackQ;
    countNext  = countQ;
    stickyNext = stickyQ;
    erroNext   = 1'b0;
    reject     = 1'b0;
    pushData   = (opCode == OP_DUP) ? stackQ[topIdx] : D;

    if (op_valid) begin
      case (opCode)
        OP_NOP: ;

        OP_PUSH, OP_DUP: begin
          if (opCode == OP_DUP && countQ == ZERO) begin
            reject = 1'b1;
          end else if (countQ != FULL) begin
            stackNext[freeIdx] = pushData;
            countNext          = countQ + ONE;
          end else if (DROP_ON_FULL) begin
            // Oldest entry falls off the bottom; depth stays at DEPTH.
            for (int i = 0; i < DEPTH - 1; i++) begin
              stackNext[i] = stackQ[i+1];
            end
            stackNext[DEPTH-1] = pushData;
          end else begin
            reject = 1'b1;
          end
        end

        OP_POP: begin
          if (countQ == ZERO) begin
            reject = 1'b1;
          end else begin
            stackNext[topIdx] = '0;
            countNext         = countQ - ONE;
          end
        end

        OP_SWAP: begin
          if (countQ < TWO) begin
            reject = 1'b1;
          end else begin
            stackNext[topIdx] = stackQ[secIdx];
            stackNext[secIdx] = stackQ[topIdx];
          end
        end

        OP_REDUCE: begin
          // ALU consumed A and B; its result replaces A and the old top slot is vacated.
          if (countQ < TWO) begin
            reject = 1'b1;
          end else begin
            stackNext[secIdx] = D;
            stackNext[topIdx] = '0;
            countNext         = countQ - ONE;
          end
        end

        OP_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) begin
            stackNext[i] = '0;
          end
          countNext  = ZERO;
          stickyNext = 1'b0;
        end

        default: reject = 1'b1;
      endcase
    end

    if (reject) begin
      erroNext   = 1'b1;
      stickyNext = 1'b1;
    end
  end

  // NOTE: the storage array is reset along with the control state because entries above the
  // top must read as zero and CLEAR has the same observable effect; sequential state uses <=.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stackQ[i] <= '0;
      end
      countQ  <= ZERO;
      erroQ   <= 1'b0;
      stickyQ <= 1'b0;
    end else begin
      stackQ  <= stackNext;
      countQ  <= countNext;
      erroQ   <= erroNext;
      stickyQ <= stickyNext;
    end
  end

  always_comb begin
    saidaB = '0;
    saidaA = '0;
    if (countQ != ZERO) saidaB = stackQ[topIdx];
    if (countQ >= TWO)  saidaA = stackQ[secIdx];
  end

  assign count       = countQ;
  assign vazia       = (countQ == ZERO);
  assign cheia       = (countQ == FULL);
  assign erro        = erroQ;
  assign erro_sticky = stickyQ;

endmodule

// File: tb/tb_pilha_rpn_n.sv
// Bench for pilha_rpn_n: two instances (DROP_ON_FULL 0 and 1) share stimulus and are compared
// against a queue-based reference model of the stack.
module tb_pilha_rpn_n;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, DUP = 3'b011,
                         SWAP = 3'b100, REDUCE = 3'b101, CLEAR = 3'b110, RSVD = 3'b111;

  typedef logic [7:0] byteQ [$];

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] D;
  logic [2:0]       op;
  logic             op_valid;

  logic [WIDTH-1:0] saidaA0, saidaB0, saidaA1, saidaB1;
  logic [2:0]       count0, count1;
  logic             vazia0, cheia0, erro0, sticky0;
  logic             vazia1, cheia1, erro1, sticky1;

  int nChecks = 0;
  int nFails  = 0;

  byteQ q0, q1;
  bit   st0, st1, rj0, rj1;

  always #5 clk = ~clk;

  pilha_rpn_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_ON_FULL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .D(D), .op(op), .op_valid(op_valid),
    .saidaA(saidaA0), .saidaB(saidaB0), .count(count0), .vazia(vazia0), .cheia(cheia0),
    .erro(erro0), .erro_sticky(sticky0)
  );

  pilha_rpn_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_ON_FULL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .D(D), .op(op), .op_valid(op_valid),
    .saidaA(saidaA1), .saidaB(saidaB1), .count(count1), .vazia(vazia1), .cheia(cheia1),
    .erro(erro1), .erro_sticky(sticky1)
  );

  // Reference model: the stack as a queue, back = top.
  task automatic modelOp(input bit drop, input logic [2:0] o, input logic [7:0] d,
                         input byteQ qi, output byteQ qo, output bit rej);
    logic [7:0] v;
    int n;
    qo  = qi;
    rej = 1'b0;
    n   = qo.size();
    case (o)
      PUSH, DUP: begin
        if (o == DUP && n == 0) rej = 1'b1;
        else begin
          v = (o == DUP) ? qo[n-1] : d;
          if (n < DEPTH) qo.push_back(v);
          else if (drop) begin
            void'(qo.pop_front());
            qo.push_back(v);
          end else rej = 1'b1;
        end
      end
      POP:    if (n < 1) rej = 1'b1; else void'(qo.pop_back());
      SWAP:   if (n < 2) rej = 1'b1; else begin v = qo[n-1]; qo[n-1] = qo[n-2]; qo[n-2] = v; end
      REDUCE: if (n < 2) rej = 1'b1; else begin void'(qo.pop_back()); qo[n-2] = d; end
      CLEAR:  qo.delete();
      RSVD:   rej = 1'b1;
      default: ;
    endcase
  endtask

  function automatic logic [7:0] expB(input byteQ q);
    return (q.size() >= 1) ? q[q.size()-1] : 8'h00;
  endfunction

  function automatic logic [7:0] expA(input byteQ q);
    return (q.size() >= 2) ? q[q.size()-2] : 8'h00;
  endfunction

  // Drive one cycle of stimulus and advance the model; outputs are sampled 1 ns after the edge.
  task automatic cmdFull(input logic [2:0] o, input logic [7:0] d, input logic v, input logic r);
    byteQ t;
    @(negedge clk);
    op = o; D = d; op_valid = v; rst = r;
    @(posedge clk);
    if (!r) begin
      q0.delete(); q1.delete();
      st0 = 1'b0; st1 = 1'b0; rj0 = 1'b0; rj1 = 1'b0;
    end else if (v) begin
      modelOp(1'b0, o, d, q0, t, rj0); q0 = t;
      modelOp(1'b1, o, d, q1, t, rj1); q1 = t;
      if (o == CLEAR) begin st0 = 1'b0; st1 = 1'b0; end
      if (rj0) st0 = 1'b1;
      if (rj1) st1 = 1'b1;
    end else begin
      rj0 = 1'b0; rj1 = 1'b0;
    end
    #1;
  endtask

  task automatic cmd(input logic [2:0] o, input logic [7:0] d);
    cmdFull(o, d, 1'b1, 1'b1);
  endtask

  task automatic test_reset;
    cmdFull(PUSH, 8'hAA, 1'b1, 1'b0);
    cmdFull(NOP, 8'h00, 1'b0, 1'b0);
    nChecks++; if (count0 !== 3'd0) begin nFails++; $display("FAIL reset_count got=%0d exp=0", count0); end
    nChecks++; if (vazia0 !== 1'b1 || cheia0 !== 1'b0) begin nFails++; $display("FAIL reset_flags vazia=%b cheia=%b exp 1/0", vazia0, cheia0); end
    nChecks++; if (saidaA0 !== 8'h00 || saidaB0 !== 8'h00) begin nFails++; $display("FAIL reset_out A=%h B=%h exp 00/00", saidaA0, saidaB0); end
    nChecks++; if (erro0 !== 1'b0 || sticky0 !== 1'b0 || erro1 !== 1'b0 || count1 !== 3'd0) begin nFails++; $display("FAIL reset_err erro=%b sticky=%b erro1=%b count1=%0d exp 0", erro0, sticky0, erro1, count1); end
  endtask

  task automatic test_push_two;
    cmd(PUSH, 8'h11);
    cmd(PUSH, 8'h22);
    nChecks++; if (count0 !== 3'd2) begin nFails++; $display("FAIL push2_count got=%0d exp=2", count0); end
    nChecks++; if (saidaA0 !== 8'h11) begin nFails++; $display("FAIL push2_A got=%h exp=11", saidaA0); end
    nChecks++; if (saidaB0 !== 8'h22) begin nFails++; $display("FAIL push2_B got=%h exp=22", saidaB0); end
    nChecks++; if (vazia0 !== 1'b0 || erro0 !== 1'b0) begin nFails++; $display("FAIL push2_flags vazia=%b erro=%b exp 0/0", vazia0, erro0); end
  endtask

  task automatic test_overflow;
    cmd(CLEAR, 8'h00);
    for (int i = 1; i <= 4; i++) cmd(PUSH, 8'(i));
    nChecks++; if (cheia0 !== 1'b1 || cheia1 !== 1'b1) begin nFails++; $display("FAIL full_cheia got=%b/%b exp=1/1", cheia0, cheia1); end
    cmd(PUSH, 8'h05);
    nChecks++; if (erro0 !== 1'b1 || sticky0 !== 1'b1) begin nFails++; $display("FAIL ovf_err erro=%b sticky=%b exp=1/1", erro0, sticky0); end
    nChecks++; if (saidaB0 !== 8'h04 || saidaA0 !== 8'h03 || count0 !== 3'd4) begin nFails++; $display("FAIL ovf_keep B=%h A=%h count=%0d exp 04/03/4", saidaB0, saidaA0, count0); end
    nChecks++; if (saidaB1 !== 8'h05 || saidaA1 !== 8'h04 || count1 !== 3'd4) begin nFails++; $display("FAIL drop_top B=%h A=%h count=%0d exp 05/04/4", saidaB1, saidaA1, count1); end
    nChecks++; if (erro1 !== 1'b0 || sticky1 !== 1'b0) begin nFails++; $display("FAIL drop_err erro=%b sticky=%b exp=0/0", erro1, sticky1); end
    cmd(NOP, 8'h00);
    nChecks++; if (erro0 !== 1'b0 || sticky0 !== 1'b1) begin nFails++; $display("FAIL ovf_pulse erro=%b sticky=%b exp=0/1", erro0, sticky0); end
    for (int i = 0; i < 3; i++) cmd(POP, 8'h00);
    nChecks++; if (saidaB1 !== 8'h02 || count1 !== 3'd1) begin nFails++; $display("FAIL drop_bottom B=%h count=%0d exp 02/1", saidaB1, count1); end
    nChecks++; if (saidaB0 !== 8'h01 || count0 !== 3'd1) begin nFails++; $display("FAIL ovf_bottom B=%h count=%0d exp 01/1", saidaB0, count0); end
  endtask

  task automatic test_underflow;
    cmd(CLEAR, 8'h00);
    cmd(POP, 8'h00);
    nChecks++; if (erro0 !== 1'b1 || count0 !== 3'd0 || sticky0 !== 1'b1) begin nFails++; $display("FAIL pop_empty erro=%b count=%0d sticky=%b exp 1/0/1", erro0, count0, sticky0); end
    cmd(NOP, 8'h00);
    nChecks++; if (erro0 !== 1'b0) begin nFails++; $display("FAIL pop_pulse erro=%b exp=0", erro0); end
    cmd(PUSH, 8'h09);
    cmd(SWAP, 8'h00);
    nChecks++; if (erro0 !== 1'b1 || count0 !== 3'd1 || saidaB0 !== 8'h09) begin nFails++; $display("FAIL swap_one erro=%b count=%0d B=%h exp 1/1/09", erro0, count0, saidaB0); end
    cmd(DUP, 8'h00);
    cmd(CLEAR, 8'h00);
    nChecks++; if (sticky0 !== 1'b0 || count0 !== 3'd0 || erro0 !== 1'b0) begin nFails++; $display("FAIL clear sticky=%b count=%0d erro=%b exp 0/0/0", sticky0, count0, erro0); end
    cmd(RSVD, 8'h00);
    nChecks++; if (erro0 !== 1'b1 || erro1 !== 1'b1 || count0 !== 3'd0) begin nFails++; $display("FAIL reserved erro=%b/%b count=%0d exp 1/1/0", erro0, erro1, count0); end
    cmd(DUP, 8'h00);
    nChecks++; if (erro0 !== 1'b1 || count0 !== 3'd0) begin nFails++; $display("FAIL dup_empty erro=%b count=%0d exp 1/0", erro0, count0); end
  endtask

  task automatic test_reduce;
    cmd(CLEAR, 8'h00);
    cmd(PUSH, 8'h07);
    cmd(PUSH, 8'h03);
    cmd(REDUCE, 8'h0A);
    nChecks++; if (count0 !== 3'd1 || saidaB0 !== 8'h0A || saidaA0 !== 8'h00 || erro0 !== 1'b0) begin nFails++; $display("FAIL reduce count=%0d B=%h A=%h erro=%b exp 1/0A/00/0", count0, saidaB0, saidaA0, erro0); end
    cmd(POP, 8'h00);
    cmd(PUSH, 8'h01);
    nChecks++; if (saidaA0 !== 8'h00 || count0 !== 3'd1) begin nFails++; $display("FAIL reduce_cleared A=%h count=%0d exp 00/1", saidaA0, count0); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] seqOp  [4];
    logic [2:0] seqCnt [4];
    seqOp  = '{PUSH, DUP, SWAP, POP};
    seqCnt = '{3'd1, 3'd2, 3'd2, 3'd1};
    cmd(CLEAR, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cmd(seqOp[i], 8'h05);
      nChecks++;
      if (count0 !== seqCnt[i] || saidaB0 !== 8'h05 || erro0 !== 1'b0) begin
        nFails++;
        $display("FAIL b2b step=%0d count=%0d B=%h erro=%b exp %0d/05/0", i, count0, saidaB0, erro0, seqCnt[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    cmd(CLEAR, 8'h00);
    cmd(POP, 8'h00);
    for (int i = 0; i < 3; i++) cmd(PUSH, 8'(8'h30 + i));
    cmdFull(PUSH, 8'hFF, 1'b1, 1'b0);
    nChecks++; if (count0 !== 3'd0 || saidaB0 !== 8'h00 || erro0 !== 1'b0 || sticky0 !== 1'b0) begin nFails++; $display("FAIL rst_mid count=%0d B=%h erro=%b sticky=%b exp 0/00/0/0", count0, saidaB0, erro0, sticky0); end
    nChecks++; if (count1 !== 3'd0 || saidaB1 !== 8'h00) begin nFails++; $display("FAIL rst_mid1 count=%0d B=%h exp 0/00", count1, saidaB1); end
  endtask

  task automatic test_random;
    logic [2:0] o;
    logic       v, r;
    for (int cyc = 0; cyc < 600; cyc++) begin
      o = 3'($urandom_range(0, 7));
      if (o == CLEAR && $urandom_range(0, 3) != 0) o = PUSH;
      if ($urandom_range(0, 3) == 0) o = PUSH;
      v = ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 99) != 0);
      cmdFull(o, 8'($urandom), v, r);
      nChecks++; if (int'(count0) !== q0.size() || saidaB0 !== expB(q0) || saidaA0 !== expA(q0)) begin nFails++; $display("FAIL rand_data0 cyc=%0d count=%0d B=%h A=%h exp %0d/%h/%h", cyc, count0, saidaB0, saidaA0, q0.size(), expB(q0), expA(q0)); end
      nChecks++; if (int'(count1) !== q1.size() || saidaB1 !== expB(q1) || saidaA1 !== expA(q1)) begin nFails++; $display("FAIL rand_data1 cyc=%0d count=%0d B=%h A=%h exp %0d/%h/%h", cyc, count1, saidaB1, saidaA1, q1.size(), expB(q1), expA(q1)); end
      nChecks++; if (vazia0 !== (q0.size() == 0) || cheia0 !== (q0.size() == DEPTH) || erro0 !== rj0 || sticky0 !== st0) begin nFails++; $display("FAIL rand_flags0 cyc=%0d vazia=%b cheia=%b erro=%b sticky=%b exp erro=%b sticky=%b", cyc, vazia0, cheia0, erro0, sticky0, rj0, st0); end
      nChecks++; if (vazia1 !== (q1.size() == 0) || cheia1 !== (q1.size() == DEPTH) || erro1 !== rj1 || sticky1 !== st1) begin nFails++; $display("FAIL rand_flags1 cyc=%0d vazia=%b cheia=%b erro=%b sticky=%b exp erro=%b sticky=%b", cyc, vazia1, cheia1, erro1, sticky1, rj1, st1); end
    end
  endtask

  initial begin
    rst = 1'b0; D = '0; op = NOP; op_valid = 1'b0;
    test_reset();
    test_push_two();
    test_overflow();
    test_underflow();
    test_reduce();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
